// File: rtl/aes_key_sched.sv
// aes_key_sched: iterative AES key expansion, one schedule word per cycle,
// with a registered round-key read port.
module aes_key_sched #(
    parameter int Nk = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic [32*Nk-1:0] i_key_in,
    output logic             o_busy,
    output logic             o_ready,
    output logic             o_key_valid,
    input  logic [3:0]       i_rk_idx,
    output logic [127:0]     o_rk_out
);
    localparam int Nr = Nk + 6;
    localparam int W  = 4 * (Nr + 1);
    localparam int IW = $clog2(W);
    localparam logic [IW-1:0] NKI  = IW'(Nk);
    localparam logic [IW-1:0] LAST = IW'(W - 1);
    localparam logic [2:0]    JL   = 3'(Nk - 1);
    localparam logic [3:0]    NR4  = 4'(Nr);
    localparam logic [1:0] IDLE = 2'd0, EXPAND = 2'd1, DONE = 2'd2;
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sb(input logic [7:0] b);
        return SBOX[{~b, 3'b000} +: 8];
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] x);
        return {sb(x[31:24]), sb(x[23:16]), sb(x[15:8]), sb(x[7:0])};
    endfunction

    logic [31:0]   r_w [W];
    logic [1:0]    r_state;
    logic [IW-1:0] r_i;
    logic [2:0]    r_j;
    logic [7:0]    r_rc;
    logic          r_key_valid;
    logic [127:0]  r_rk;
    logic          w_accept;
    logic [31:0]   w_prev;
    logic [31:0]   w_temp;
    logic [31:0]   w_new;
    logic [IW-1:0] w_rk_base;

    // r_j tracks i mod Nk and r_rc the running Rcon, so no divider is needed
    assign w_accept  = (r_state == IDLE) && i_start;
    assign w_prev    = r_w[r_i - IW'(1)];
    assign w_temp    = (r_j == 3'd0) ? sub_word({w_prev[23:0], w_prev[31:24]}) ^ {r_rc, 24'h0}
                     : (Nk == 8 && r_j == 3'd4) ? sub_word(w_prev) : w_prev;
    assign w_new     = r_w[r_i - NKI] ^ w_temp;
    assign w_rk_base = IW'({i_rk_idx, 2'b00});

    always_ff @(posedge clk) begin
        if (!rst && w_accept)
            for (int k = 0; k < Nk; k++) r_w[k] <= i_key_in[32*(Nk-k)-1 -: 32];
        else if (!rst && r_state == EXPAND)
            r_w[r_i] <= w_new;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_i         <= '0;
            r_j         <= '0;
            r_rc        <= 8'h01;
            r_key_valid <= 1'b0;
            r_rk        <= '0;
        end else begin
            r_rk <= (i_rk_idx > NR4) ? 128'h0
                  : {r_w[w_rk_base], r_w[w_rk_base + IW'(1)], r_w[w_rk_base + IW'(2)], r_w[w_rk_base + IW'(3)]};
            case (r_state)
                IDLE: if (i_start) begin
                    r_state     <= EXPAND;
                    r_i         <= NKI;
                    r_j         <= '0;
                    r_rc        <= 8'h01;
                    r_key_valid <= 1'b0;
                end
                EXPAND: begin
                    r_i <= r_i + IW'(1);
                    r_j <= (r_j == JL) ? 3'd0 : r_j + 3'd1;
                    if (r_j == 3'd0) r_rc <= {r_rc[6:0], 1'b0} ^ (r_rc[7] ? 8'h1b : 8'h00);
                    if (r_i == LAST) begin
                        r_state     <= DONE;
                        r_key_valid <= 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_busy      = r_state != IDLE;
    assign o_ready     = r_state == DONE;
    assign o_key_valid = r_key_valid;
    assign o_rk_out    = r_rk;
endmodule

// File: tb/tb_aes_key_sched.sv
// tb_aes_key_sched: checks Nk=4/6/8 instances against a FIPS-197 reference model
// whose S-box is derived from GF(2^8) inversion rather than a table.
module tb_aes_key_sched;
    logic         clk;
    logic         rst;
    logic         start;
    logic [255:0] key;
    logic [3:0]   rk_idx;
    logic         busy [3];
    logic         ready [3];
    logic         kv [3];
    logic [127:0] rk [3];

    int tests = 0;
    int fails = 0;
    bit armed = 0;

    int           nks [3] = '{4, 6, 8};
    logic [7:0]   sbox_t [256];
    logic [7:0]   rcon_t [11];
    logic [31:0]  sched [3][60];
    int           cnt [3];
    bit           kv_m [3];
    bit           rk_chk [3];
    logic [127:0] rk_m [3];
    int           m_n, m_lat, m_i;

    aes_key_sched #(.Nk(4)) dut4 (.clk(clk), .rst(rst), .i_start(start), .i_key_in(key[255:128]),
        .o_busy(busy[0]), .o_ready(ready[0]), .o_key_valid(kv[0]), .i_rk_idx(rk_idx), .o_rk_out(rk[0]));
    aes_key_sched #(.Nk(6)) dut6 (.clk(clk), .rst(rst), .i_start(start), .i_key_in(key[255:64]),
        .o_busy(busy[1]), .o_ready(ready[1]), .o_key_valid(kv[1]), .i_rk_idx(rk_idx), .o_rk_out(rk[1]));
    aes_key_sched #(.Nk(8)) dut8 (.clk(clk), .rst(rst), .i_start(start), .i_key_in(key),
        .o_busy(busy[2]), .o_ready(ready[2]), .o_key_valid(kv[2]), .i_rk_idx(rk_idx), .o_rk_out(rk[2]));

    initial clk = 0;
    always #5 clk = ~clk;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int s);
        logic [15:0] d;
        d = {v, v} << s;
        return d[15:8];
    endfunction

    function automatic logic [31:0] sub_m(input logic [31:0] x);
        return {sbox_t[x[31:24]], sbox_t[x[23:16]], sbox_t[x[15:8]], sbox_t[x[7:0]]};
    endfunction

    task automatic expand(input int d);
        int n;
        logic [31:0] t;
        n = nks[d];
        for (int k = 0; k < n; k++) sched[d][k] = key[255-32*k -: 32];
        for (int k = n; k < 4 * (n + 7); k++) begin
            t = sched[d][k-1];
            if (k % n == 0) t = sub_m({t[23:0], t[31:24]}) ^ {rcon_t[k/n], 24'h0};
            else if (n > 6 && k % n == 4) t = sub_m(t);
            sched[d][k] = sched[d][k-n] ^ t;
        end
    endtask

    task automatic check(input string nm, input int d, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s (Nk=%0d): got %h expected %h", nm, nks[d], act, exp);
        end
    endtask

    // Model: time since accepted load; DONE is the (latency+1)th cycle after it.
    always @(posedge clk) begin
        for (int d = 0; d < 3; d++) begin
            m_n   = nks[d];
            m_lat = 3 * m_n + 28;
            m_i   = int'(rk_idx);
            if (rst) begin
                cnt[d] = 0;
                kv_m[d] = 0;
                rk_m[d] = '0;
                rk_chk[d] = 1;
            end else begin
                rk_chk[d] = kv_m[d] || m_i > m_n + 6;
                if (m_i > m_n + 6) rk_m[d] = '0;
                else rk_m[d] = {sched[d][4*m_i], sched[d][4*m_i+1], sched[d][4*m_i+2], sched[d][4*m_i+3]};
                if (cnt[d] == 0) begin
                    if (start) begin
                        cnt[d] = 1;
                        kv_m[d] = 0;
                        expand(d);
                    end
                end else if (cnt[d] == m_lat + 1) cnt[d] = 0;
                else begin
                    cnt[d]++;
                    if (cnt[d] == m_lat + 1) kv_m[d] = 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            for (int d = 0; d < 3; d++) begin
                check("busy", d, 128'(busy[d]), 128'(cnt[d] != 0));
                check("ready", d, 128'(ready[d]), 128'(cnt[d] == 3 * nks[d] + 29));
                check("key_valid", d, 128'(kv[d]), 128'(kv_m[d]));
                if (rk_chk[d]) check("rk_out", d, rk[d], rk_m[d]);
            end
        end
    end

    task automatic wait_ready(input int d, output int n);
        n = 1;
        while (!ready[d] && n < 200) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic wait_idle();
        int c;
        c = 0;
        while ((busy[0] || busy[1] || busy[2]) && c < 200) begin
            @(negedge clk);
            c++;
        end
        @(negedge clk);
    endtask

    task automatic read_rk(input logic [3:0] idx);
        rk_idx = idx;
        @(negedge clk);
    endtask

    task automatic load(input logic [255:0] k);
        key = k;
        start = 1;
        @(negedge clk);
        start = 0;
    endtask

    initial begin
        int n;
        int pulses [3];
        bit seen;
        rst = 1;
        start = 0;
        key = '0;
        rk_idx = 0;
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv;
            inv = 8'h00;
            for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sbox_t[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
        rcon_t[0] = 8'h00;
        rcon_t[1] = 8'h01;
        for (int j = 2; j < 11; j++) rcon_t[j] = gmul(rcon_t[j-1], 8'h02);
        check("model_sbox_00", 0, 128'(sbox_t[8'h00]), 128'h63);
        check("model_sbox_53", 0, 128'(sbox_t[8'h53]), 128'hed);
        check("model_rcon10", 0, 128'(rcon_t[10]), 128'h36);
        @(negedge clk);
        @(negedge clk);
        armed = 1;
        check("reset_busy", 0, 128'(busy[0]), 128'h0);
        check("reset_ready", 0, 128'(ready[0]), 128'h0);
        check("reset_kv", 0, 128'(kv[0]), 128'h0);
        check("reset_rk", 0, rk[0], 128'h0);
        rst = 0;
        @(negedge clk);

        load({128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0});
        wait_ready(0, n);
        check("latency128", 0, 128'(n), 128'd41);
        read_rk(4'd1);
        check("aes128_rk1", 0, rk[0], 128'ha0fafe1788542cb123a339392a6c7605);
        read_rk(4'd10);
        check("aes128_rk10", 0, rk[0], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        read_rk(4'd0);
        check("aes128_rk0", 0, rk[0], 128'h2b7e151628aed2a6abf7158809cf4f3c);
        wait_idle();

        load(256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f);
        wait_ready(2, n);
        check("latency256", 2, 128'(n), 128'd53);
        read_rk(4'd14);
        check("aes256_rk14", 2, rk[2], 128'h24fc79ccbf0979e9371ac23c6d68de36);
        read_rk(4'd15);
        check("aes256_rk15", 2, rk[2], 128'h0);
        wait_idle();

        load({128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0});
        repeat (19) @(negedge clk);
        rst = 1;
        @(negedge clk);
        rst = 0;
        seen = 0;
        repeat (60) begin
            @(negedge clk);
            if (ready[0]) seen = 1;
        end
        check("abort_no_ready", 0, 128'(seen), 128'h0);
        check("abort_kv", 0, 128'(kv[0]), 128'h0);
        load({128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0});
        wait_ready(0, n);
        check("relatency128", 0, 128'(n), 128'd41);
        read_rk(4'd10);
        check("reload_rk10", 0, rk[0], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        wait_idle();

        check("kv_before_zero", 0, 128'(kv[0]), 128'h1);
        load('0);
        check("kv_drop", 0, 128'(kv[0]), 128'h0);
        wait_ready(0, n);
        check("latency_zero", 0, 128'(n), 128'd41);
        read_rk(4'd10);
        check("zero_rk10", 0, rk[0], 128'hb4ef5bcb3e92e21123e951cf6f8f188e);
        read_rk(4'd11);
        check("zero_rk11", 0, rk[0], 128'h0);
        wait_idle();

        pulses = '{0, 0, 0};
        key = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        start = 1;
        for (int c = 0; c < 160; c++) begin
            @(negedge clk);
            if (c == 59) start = 0;
            for (int d = 0; d < 3; d++) if (ready[d]) pulses[d]++;
        end
        for (int d = 0; d < 3; d++) check("held_start_pulses", d, 128'(pulses[d]), 128'd2);

        for (int c = 0; c < 3000; c++) begin
            start = ($urandom_range(0, 7) == 0);
            rst = ($urandom_range(0, 299) == 0);
            rk_idx = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0)
                key = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            @(negedge clk);
        end
        rst = 0;
        start = 0;
        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/aes_key_sched.md
AES_KEY_SCHED -- requirements
Module: aes_key_sched

Interface
REQ-001 Parameter: Nk, default 4, key length in 32-bit words; legal values 4, 6, 8; Nr = Nk+6; W = 4*(Nr+1) total schedule words.
REQ-002 clk  input  1  single clock, all state updates on rising edge.
REQ-003 rst  input  1  reset is synchronous and active-high.
REQ-004 start  input  1  key-load request, sampled on the rising edge.
REQ-005 key_in  input  32*Nk  cipher key; bits [32*Nk-1 -: 32] form w[0].
REQ-006 busy  output  1  high while expansion is in progress.
REQ-007 ready  output  1  one-cycle pulse when the schedule is complete.
REQ-008 key_valid  output  1  high while the stored schedule is complete and consistent.
REQ-009 rk_idx  input  4  round-key index, 0..Nr.
REQ-010 rk_out  output  128  round key {w[4r], w[4r+1], w[4r+2], w[4r+3]} for r = rk_idx.

Function
REQ-011 FSM states: IDLE, EXPAND, DONE.
REQ-012 IDLE + start=1: latch key_in into w[0..Nk-1], clear key_valid, set word counter i=Nk, go to EXPAND.
REQ-013 start while in EXPAND or DONE: ignored, no effect on state, counter, or storage.
REQ-014 start in IDLE while key_valid=1: accepted; key_valid falls on the same edge; the old schedule is overwritten.
REQ-015 EXPAND: exactly one word per cycle; temp = w[i-1].
- If i mod Nk == 0: temp = SubWord(RotWord(temp)) ^ {Rcon[i/Nk], 24'h0}.
- Else if Nk == 8 and i mod Nk == 4: temp = SubWord(temp).
- Write w[i] = w[i-Nk] ^ temp; increment i.
REQ-016 Rcon[1..10] = 01,02,04,08,10,20,40,80,1b,36; SubWord applies the FIPS-197 forward S-box to each byte; RotWord rotates left by one byte.
REQ-017 EXPAND -> DONE on the edge that writes w[W-1].
- EXPAND lasts W-Nk cycles: 40 for Nk=4, 46 for Nk=6, 52 for Nk=8.
REQ-018 DONE: ready=1 and key_valid=1 for this cycle; next state IDLE; key_valid stays 1 afterwards.
REQ-019 Latency: ready asserts exactly W-Nk+1 cycles after the edge that samples start (41 for AES-128).
REQ-020 busy = 1 in EXPAND and DONE, 0 in IDLE.
REQ-021 ready is never high for more than one consecutive cycle.
REQ-022 rk_out is registered: the value for rk_idx sampled at edge n appears after edge n and holds until the next edge.
REQ-023 rk_idx > Nr: rk_out = 0.
REQ-024 Reads while key_valid=0: rk_out reflects the current storage contents and carries no correctness guarantee.
REQ-025 Storage is written only in the IDLE-accept cycle and in EXPAND.

Reset
REQ-026 rst=1 at an edge forces state IDLE, i=0, busy=0, ready=0, key_valid=0, rk_out=0; storage contents are don't-care.
REQ-027 rst during EXPAND aborts the expansion: no ready pulse and key_valid=0 until a fresh start completes.
REQ-028 rst has priority over start on the same edge.

Verification
REQ-029 Nk=4, key 2b7e151628aed2a6abf7158809cf4f3c, start pulse ->
- ready exactly 41 cycles later;
- rk_idx=1 gives a0fafe1788542cb123a339392a6c7605;
- rk_idx=10 gives d014f9a8c9ee2589e13f0cc8b6630ca6;
- rk_idx=0 returns the key.
REQ-030 Nk=8, key 000102...1f, start pulse ->
- ready 53 cycles later;
- rk_idx=14 gives 24fc79ccbf0979e9371ac23c6d68de36.
REQ-031 start held high continuously for 60 cycles after a load ->
- one ready pulse per accepted load;
- no accepted re-start until IDLE is reached;
- busy high throughout each EXPAND/DONE interval.
REQ-032 rst pulse at cycle 20 of an AES-128 expansion ->
- no ready pulse;
- key_valid=0;
- a subsequent start with the same key reproduces REQ-029 results.
REQ-033 After a valid schedule, start with key 000...0 ->
- key_valid drops on the next edge;
- ready after 41 cycles;
- rk_idx=10 gives b4ef5bcb3e92e21123e951cf6f8f188e;
- rk_idx=11 gives 0.
